fl_checkpoint_ctrl: RTL
=======================

// Module: fl_checkpoint_ctrl
// PURPOSE
// - Branch-checkpoint controller for the integer free list, sitting beside it in the rename stage.
// - Allocates one checkpoint slot per renamed branch and stores a snapshot of the post-rename free-list bitmap (1=busy).
// - Keeps every live snapshot coherent with commit-time frees.
// - On mispredict, drives the free list's recover/recover_fl pair and squashes younger checkpoints.
// PARAMETERS
// - PRF_SIZE      64  physical int registers (bitmap width)
// - PRF_IDX_W     6   $clog2(PRF_SIZE)
// - COMMIT_WIDTH  4   retire ports
// - NUM_CKPT      4   checkpoint slots
// - CKPT_IDX_W    2   $clog2(NUM_CKPT)
// PORTS
// - clock          in   1                       clock
// - reset          in   1                       synchronous, active-high
// - stall          in   1                       rename stall; ckpt_req ignored while 1
// - ckpt_req       in   1                       branch renamed this cycle, needs a slot
// - ckpt_fl        in   PRF_SIZE                free-list bitmap after this cycle's allocations
// - ckpt_grant     out  1                       comb: ckpt_req & ~stall & ~ckpt_full & ~br_squash
// - ckpt_tag       out  CKPT_IDX_W              comb: slot granted (lowest free index)
// - ckpt_full      out  1                       registered-state: all slots valid
// - active_mask    out  NUM_CKPT                registered valid vector; attached to renamed uops
// - br_valid       in   1                       branch resolved
// - br_tag         in   CKPT_IDX_W              its checkpoint slot
// - br_mispredict  in   1                       qualifies br_valid
// - retire_valid   in   COMMIT_WIDTH            commit frees
// - retire_prf     in   COMMIT_WIDTH*PRF_IDX_W   freed register indices
// - recover        out  1                       registered pulse to the free list
// - recover_fl     out  PRF_SIZE                registered snapshot to restore
// BEHAVIOUR
// - Reset: valid=0, all older_mask=0, recover=0, recover_fl=0, ckpt_full=0, active_mask=0.
// - Per-slot state: valid, snap[PRF_SIZE], older_mask[NUM_CKPT].
// - Allocate on ckpt_grant, effective next edge:
//   - valid[t]=1.
//   - older_mask[t]=valid of every slot that remains valid this cycle.
//   - snap[t]=ckpt_fl with same-cycle retire bits cleared.
// - Retire: each retire_valid[i] clears bit retire_prf[i] in snap of every valid slot, same edge.
// - Correct resolve (br_valid & ~br_mispredict):
//   - valid[br_tag]=0.
//   - Bit br_tag cleared in every older_mask.
// - Mispredict (br_squash = br_valid & br_mispredict):
//   - Next edge: recover=1 and recover_fl=snap[br_tag] with same-cycle retire bits cleared.
//   - Slot br_tag invalidated, plus every slot whose older_mask[br_tag]=1 (younger).
//   - recover returns to 0 the following cycle unless another mispredict occurs.
//   - Latency: resolve to recover is 1 cycle.
// - br_valid on an invalid slot: ignored, no state change. Verification treats it as an assertion error.
// - Freed slots are not re-grantable in the same cycle: ckpt_full and the free index come from registered valid.
// - Mispredict and ckpt_req in the same cycle: the request is younger and is dropped (ckpt_grant=0).
// - Slot selection: lowest index with valid=0. No wrap ordering; age is held only in older_mask.
// - stall blocks allocation only. Resolve, retire and recover proceed during stall.
// - Reset mid-recovery: reset wins; recover=0 next cycle.
// STRUCTURE
// - Shared package (micro_op.svh): NUM_CKPT, CKPT_IDX_SIZE, ckpt_tag_t, ckpt_mask_t.
// - Sub-module fl_ckpt_slot: one slot's valid, snap and older_mask plus retire-clear logic.
//   - Instantiated NUM_CKPT times.
// - Top level: priority encoder, grant, squash-mask and recover register.
// TESTING
// - Reset, then ckpt_req with ckpt_fl=64'h1 -> grant=1, tag=0, active_mask=4'b0001.
// - Four branches, no resolve -> tags 0,1,2,3; ckpt_full=1; 5th req grant=0.
//   - Then resolve tag 2 correct -> next cycle full=0; next req tag=2.
// - Snapshot tag0 with fl=64'hFF; retire prf 3 two cycles later; mispredict tag0.
//   - -> recover=1 for exactly 1 cycle, recover_fl=64'hF7.
// - Tags 0,1,2 live; mispredict tag1 -> slots 1,2 invalid, slot 0 valid, active_mask=4'b0001.
// - Mispredict tag0 plus ckpt_req plus retire prf 5 in the same cycle.
//   - -> grant=0; recover_fl bit5=0; all slots invalid.
// - Assert reset on the cycle recover would fire -> recover=0, active_mask=0.

Source files
------------

// File: rtl/fl_checkpoint_ctrl_pkg.sv
// Shared sizes and types for the integer free-list branch checkpoint controller.
package fl_checkpoint_ctrl_pkg;

  localparam int PRF_SIZE     = 64;
  localparam int PRF_IDX_W    = $clog2(PRF_SIZE);
  localparam int COMMIT_WIDTH = 4;
  localparam int NUM_CKPT     = 4;
  localparam int CKPT_IDX_W   = $clog2(NUM_CKPT);

  typedef logic [CKPT_IDX_W-1:0] ckpt_tag_t;
  typedef logic [NUM_CKPT-1:0]   ckpt_mask_t;
  typedef logic [PRF_SIZE-1:0]   prf_vec_t;

  // One-hot union of the registers freed by commit this cycle.
  function automatic prf_vec_t retire_to_mask(
    input logic [COMMIT_WIDTH-1:0]           valid,
    input logic [COMMIT_WIDTH*PRF_IDX_W-1:0] idx
  );
    prf_vec_t m;
    m = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (valid[i]) m[idx[i*PRF_IDX_W +: PRF_IDX_W]] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/fl_checkpoint_ctrl_slot.sv
// One checkpoint slot: valid flag, free-list snapshot kept coherent with commit
// frees, and the mask of checkpoints that were live (older) when it was taken.
module fl_checkpoint_ctrl_slot
  import fl_checkpoint_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       alloc,
  input  prf_vec_t   alloc_snap,
  input  ckpt_mask_t alloc_older,
  input  logic       kill,
  input  ckpt_mask_t clr_older,
  input  prf_vec_t   retire_mask,
  output logic       valid,
  output prf_vec_t   snap,
  output ckpt_mask_t older_mask
);

  always_ff @(posedge clock) begin
    if (reset) begin
      valid      <= 1'b0;
      snap       <= '0;
      older_mask <= '0;
    end else if (alloc) begin
      valid      <= 1'b1;
      snap       <= alloc_snap & ~retire_mask;
      older_mask <= alloc_older;
    end else begin
      if (kill) valid <= 1'b0;
      if (valid) snap <= snap & ~retire_mask;
      older_mask <= older_mask & ~clr_older;
    end
  end

endmodule

// File: rtl/fl_checkpoint_ctrl.sv
// Branch checkpoint controller beside the integer free list: allocates slots,
// tracks age via older masks, and restores the free list on mispredict.
module fl_checkpoint_ctrl
  import fl_checkpoint_ctrl_pkg::*;
(
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              stall,
  input  logic                              ckpt_req,
  input  logic [PRF_SIZE-1:0]               ckpt_fl,
  output logic                              ckpt_grant,
  output logic [CKPT_IDX_W-1:0]             ckpt_tag,
  output logic                              ckpt_full,
  output logic [NUM_CKPT-1:0]               active_mask,
  input  logic                              br_valid,
  input  logic [CKPT_IDX_W-1:0]             br_tag,
  input  logic                              br_mispredict,
  input  logic [COMMIT_WIDTH-1:0]           retire_valid,
  input  logic [COMMIT_WIDTH*PRF_IDX_W-1:0] retire_prf,
  output logic                              recover,
  output logic [PRF_SIZE-1:0]               recover_fl
);

  ckpt_mask_t valid;
  prf_vec_t   snap  [NUM_CKPT];
  ckpt_mask_t older [NUM_CKPT];

  prf_vec_t   retire_mask;
  ckpt_mask_t alloc_vec, kill_vec, clr_older, alloc_older;
  logic       br_squash, resolve_ok, squash_hit;
  ckpt_tag_t  free_idx;

  assign retire_mask = retire_to_mask(retire_valid, retire_prf);
  assign br_squash   = br_valid & br_mispredict;
  // Resolves against a dead slot are dropped entirely.
  assign resolve_ok  = br_valid & ~br_mispredict & valid[br_tag];
  assign squash_hit  = br_squash & valid[br_tag];

  always_comb begin
    free_idx = '0;
    for (int j = NUM_CKPT - 1; j >= 0; j--) begin
      if (!valid[j]) free_idx = ckpt_tag_t'(j);
    end
  end

  assign ckpt_full   = &valid;
  assign ckpt_tag    = free_idx;
  assign ckpt_grant  = ckpt_req & ~stall & ~ckpt_full & ~br_squash;
  assign active_mask = valid;

  always_comb begin
    alloc_vec = '0;
    kill_vec  = '0;
    clr_older = '0;
    if (ckpt_grant) alloc_vec[free_idx] = 1'b1;
    if (resolve_ok) begin
      clr_older[br_tag] = 1'b1;
      kill_vec[br_tag]  = 1'b1;
    end
    // Squash the mispredicted slot and everything allocated after it.
    for (int j = 0; j < NUM_CKPT; j++) begin
      if (squash_hit && valid[j] && (ckpt_tag_t'(j) == br_tag || older[j][br_tag]))
        kill_vec[j] = 1'b1;
    end
  end

  assign alloc_older = valid & ~clr_older;

  for (genvar g = 0; g < NUM_CKPT; g++) begin : g_slot
    fl_checkpoint_ctrl_slot u_slot (
      .clock       (clock),
      .reset       (reset),
      .alloc       (alloc_vec[g]),
      .alloc_snap  (ckpt_fl),
      .alloc_older (alloc_older),
      .kill        (kill_vec[g]),
      .clr_older   (clr_older),
      .retire_mask (retire_mask),
      .valid       (valid[g]),
      .snap        (snap[g]),
      .older_mask  (older[g])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      recover    <= 1'b0;
      recover_fl <= '0;
    end else begin
      recover <= squash_hit;
      if (squash_hit) recover_fl <= snap[br_tag] & ~retire_mask;
    end
  end

endmodule
